// File: rtl/program_loader_if.sv
// program_loader_if: byte-stream input, instruction-memory write port and
// boot status of the program loader. master = host/bench, slave = loader.
interface program_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  start;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;
   logic                  cpu_reset;
   logic                  done;
   logic                  error;

   modport master (
      output rx_valid, rx_data, start,
      input  rx_ready, imem_we, imem_addr, imem_wdata,
      input  cpu_reset, done, error
   );

   modport slave (
      input  rx_valid, rx_data, start,
      output rx_ready, imem_we, imem_addr, imem_wdata,
      output cpu_reset, done, error
   );
endinterface

// File: rtl/program_loader.sv
// program_loader: loads a framed byte stream (len, BE words, XOR sum)
// into instruction memory and holds the core in reset until verified.
// Ports: clk, reset (async, active-low), bus (program_loader_if.slave):
//   rx_valid/rx_data/rx_ready byte stream, start re-arm pulse,
//   imem_we/imem_addr/imem_wdata write port, cpu_reset/done/error status.
module program_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input logic             clk,
   input logic             reset,
   program_loader_if.slave bus
);
   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_e;

   state_e                state_q, state_d;
   logic [7:0]            xor_q, xor_d;
   logic [15:0]           len_q, len_d;
   logic [1:0]            bidx_q, bidx_d;
   logic [23:0]           sh_q, sh_d;
   logic [16:0]           wptr_q, wptr_d;
   logic                  rx_ready_q, rx_ready_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  cpu_reset_q, cpu_reset_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  acc;
   logic [7:0]            data;
   logic [16:0]           n_new;

   assign acc   = bus.rx_valid && rx_ready_q;
   assign data  = bus.rx_data;
   // Word count as it completes on the LEN_LO byte.
   assign n_new = {1'b0, len_q[15:8], data};

   always_comb begin
      state_d     = state_q;
      xor_d       = xor_q;
      len_d       = len_q;
      bidx_d      = bidx_q;
      sh_d        = sh_q;
      wptr_d      = wptr_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
      error_d     = error_q;
      unique case (state_q)
         S_IDLE: state_d = S_LEN_HI;
         S_LEN_HI: begin
            if (acc) begin
               len_d[15:8] = data;
               xor_d       = xor_q ^ data;
               state_d     = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (acc) begin
               len_d[7:0] = data;
               xor_d      = xor_q ^ data;
               if (n_new > MAX_WORDS) begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end else if (n_new == 17'd0) begin
                  state_d = S_CHECK;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (acc) begin
               xor_d = xor_q ^ data;
               if (bidx_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = wptr_q[ADDR_WIDTH-1:0];
                  wdata_d = {sh_q, data};
                  wptr_d  = wptr_q + 17'd1;
                  bidx_d  = 2'd0;
                  if (wptr_q + 17'd1 == {1'b0, len_q})
                     state_d = S_CHECK;
               end else begin
                  bidx_d = bidx_q + 2'd1;
                  sh_d   = {sh_q[15:0], data};
               end
            end
         end
         S_CHECK: begin
            if (acc) begin
               if (data == xor_q) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  cpu_reset_d = 1'b0;
               end else begin
                  state_d = S_ERROR;
                  error_d = 1'b1;
               end
            end
         end
         S_DONE, S_ERROR: begin
            if (bus.start) begin
               state_d     = S_LEN_HI;
               xor_d       = 8'd0;
               wptr_d      = 17'd0;
               bidx_d      = 2'd0;
               done_d      = 1'b0;
               error_d     = 1'b0;
               cpu_reset_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Registered ready follows the next state so it drops on the
      // same edge that leaves the receiving states.
      rx_ready_d = state_d inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         xor_q       <= 8'd0;
         len_q       <= 16'd0;
         bidx_q      <= 2'd0;
         sh_q        <= 24'd0;
         wptr_q      <= 17'd0;
         rx_ready_q  <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         xor_q       <= xor_d;
         len_q       <= len_d;
         bidx_q      <= bidx_d;
         sh_q        <= sh_d;
         wptr_q      <= wptr_d;
         rx_ready_q  <= rx_ready_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign bus.rx_ready   = rx_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_reset  = cpu_reset_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;
endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader that sits directly upstream of the MIPS core's instruction memory. It accepts a framed byte stream (length, big-endian instruction words, XOR checksum) over a valid/ready handshake and assembles the bytes into 32-bit words. It writes each word into instruction memory at sequential word addresses and holds the processor in reset until a complete frame with a correct checksum has been loaded.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width, legal range 1..16; capacity MAX_WORDS = 2**ADDR_WIDTH

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- rx_valid  input  1  byte on rx_data is valid
- rx_data  input  8  frame byte
- rx_ready  output  1  loader can accept a byte this cycle
- start  input  1  re-arm pulse; honoured only in DONE or ERROR
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  word address of the write
- imem_wdata  output  32  assembled instruction word
- cpu_reset  output  1  active-high hold-in-reset for the processor
- done  output  1  frame loaded and verified
- error  output  1  frame rejected

## Operation
- Frame format, in order:
  - LEN_HI byte, then LEN_LO byte: N, a 16-bit word count.
  - N×4 data bytes, big-endian per word: the first byte goes to [31:24].
  - One checksum byte, equal to the XOR of all preceding frame bytes (both length bytes included).
- A byte is accepted on a rising edge with rx_valid && rx_ready. No byte is consumed otherwise. rx_data is a don't-care when rx_valid=0.
- States and transitions:
  - IDLE -> LEN_HI: unconditional, one clock after reset release.
  - LEN_HI -> LEN_LO: on byte accept.
  - LEN_LO -> ERROR: if N > MAX_WORDS.
  - LEN_LO -> CHECK: if N = 0.
  - LEN_LO -> DATA: otherwise.
  - DATA -> CHECK: after byte 4N is accepted.
  - CHECK -> DONE: checksum byte matches the running XOR.
  - CHECK -> ERROR: checksum byte mismatches.
  - DONE or ERROR -> LEN_HI: on start=1. Clears the running XOR, byte counter and word address; done=0, error=0, cpu_reset=1.
- rx_ready=1 in LEN_HI, LEN_LO, DATA and CHECK. rx_ready=0 in IDLE, DONE and ERROR.
- start is ignored in every state other than DONE or ERROR.
- Words are written as they complete, before the checksum is verified. A bad frame therefore leaves partial contents in memory; error=1 and cpu_reset=1 keep the core from running it.
- Word address starts at 0 and increments after each write. It never wraps, because N ≤ MAX_WORDS is checked before any data is accepted.
- Running XOR is 8 bits wide and covers every accepted byte except the checksum byte itself.

## Timing
- Reset values, held while reset=0:
  - state=IDLE
  - rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_reset=1, done=0, error=0
- rx_ready first rises one clock after reset deasserts (IDLE -> LEN_HI).
- All outputs are registered.
- Write latency: imem_we=1 for exactly one cycle, in the cycle after the edge that accepts a word's 4th byte. imem_addr and imem_wdata are valid in that same cycle.
- rx_ready stays high through each write, so back-to-back bytes are accepted every cycle with no stalls.
- The edge that accepts a good checksum:
  - changes the state to DONE;
  - sets done=1 and cpu_reset=0 together, visible the following cycle;
  - drops rx_ready.
- The last word's write strobe precedes or coincides with that cycle, never follows it.
- The edge that accepts a bad checksum, or LEN_LO with N > MAX_WORDS: error=1 and rx_ready=0 the following cycle. cpu_reset stays 1.
- done and error are sticky until start or reset. They are never both 1.
- Reset mid-frame: takes effect immediately. Any partial word is discarded and any pending write is cancelled. Memory contents are undefined, but cpu_reset=1 holds the core.
- A stalled rx_valid, at any point and for any length, changes no state.

## Test plan
- Good single-word load. Stimulus: reset, then bytes 00 01 20 08 00 05 2C, back-to-back. Required: one imem_we with addr 0 and data 0x20080005; then done=1, cpu_reset=0, rx_ready=0.
- Two-word load with gaps. Stimulus: N=2, words 0x8C090004 and 0x1109FFFE, with rx_valid low for 3 cycles between bytes and the correct checksum. Required: writes to addr 0 and 1 with the correct data; done=1. Repeat with the checksum bit-inverted. Required: both writes still occur, then error=1, cpu_reset=1, done=0.
- Empty frame. Stimulus: bytes 00 00 00. Required: no imem_we; done=1, cpu_reset=0. Repeat with final byte 01. Required: error=1.
- Oversize frame with ADDR_WIDTH=8. Stimulus: length bytes 01 01 (N=257). Required: error=1 the cycle after LEN_LO is accepted; rx_ready=0; no imem_we; subsequent rx_valid bytes are ignored.
- Reset mid-DATA, then re-arm.
  - Stimulus: assert reset after 2 bytes of a word. Required: outputs at reset values immediately; no write.
  - Stimulus: release reset and load the frame from the first scenario. Required: done=1.
  - Stimulus: pulse start. Required: done=0, cpu_reset=1, rx_ready=1.
  - Stimulus: load a second frame. Required: its writes start at addr 0.
- Start ignored mid-frame. Stimulus: pulse start during DATA. Required: no state change; the load completes normally.
